// File: rtl/bus_share_arbiter_pkg.sv
// Shared constants for the bus share arbiter: FSM state encodings, default
// widths and the clog2 helper used to size index and counter fields.
package bus_share_arbiter_pkg;

    localparam int unsigned DEF_N        = 4;
    localparam int unsigned DEF_W        = 8;
    localparam int unsigned DEF_MAX_HOLD = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Index fields never shrink below one bit, even for degenerate sizes.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_share_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: returns the first set request
// at or above rr_ptr_i, wrapping at N.
module bus_share_arbiter_rr_pick
    import bus_share_arbiter_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [IW-1:0] pick_o,
    output logic          any_o
);

    int unsigned idx;

    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(rr_ptr_i) + i) % N;
            if (!any_o && req_i[idx]) begin
                any_o  = 1'b1;
                pick_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin sharing of one W-bit bus among N requesters with multi-beat holds.
// Define BUS_SHARE_ARB_TIMEOUT_EN to force release after MAX_HOLD busy cycles.
module bus_share_arbiter
    import bus_share_arbiter_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned W        = DEF_W,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          last,
    input  logic [N*W-1:0]        data_in,
    output logic [N-1:0]          grant,
    output logic [W-1:0]          bus_data,
    output logic                  bus_valid,
    output logic [idx_w(N)-1:0]   owner,
    output logic                  timeout
);

    localparam int unsigned OW = idx_w(N);
    localparam logic [N-1:0] GRANT_LSB = {{(N-1){1'b0}}, 1'b1};

    if (N < 2 || N > 8 || MAX_HOLD < 2) begin : g_bad_params
        $error("bus_share_arbiter: N must be 2..8 and MAX_HOLD at least 2");
    end

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [W-1:0]  bus_data_q, bus_data_d;
    logic          bus_valid_q, bus_valid_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;

    logic [OW-1:0] pick;
    logic          pick_any;
    logic [W-1:0]  owner_data;
    logic          owner_req;
    logic          owner_last;
    logic [OW-1:0] next_ptr;

`ifdef BUS_SHARE_ARB_TIMEOUT_EN
    localparam int unsigned HW = clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;
`endif

    bus_share_arbiter_rr_pick #(
        .N  (N),
        .IW (OW)
    ) u_rr_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .pick_o   (pick),
        .any_o    (pick_any)
    );

    always_comb begin
        owner_data = data_in[32'(owner_q) * W +: W];
        owner_req  = req[owner_q];
        owner_last = last[owner_q];
        next_ptr   = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        bus_data_d  = bus_data_q;
        bus_valid_d = 1'b0;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = GRANT_LSB << pick;
                    owner_d = pick;
                    state_d = ST_BUSY;
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                // A dropped request releases without capturing a beat.
                if (!owner_req) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = next_ptr;
                    timeout_d = 1'b1;
                end
`endif
                else begin
                    bus_data_d  = owner_data;
                    bus_valid_d = 1'b1;
`ifdef BUS_SHARE_ARB_TIMEOUT_EN
                    hold_d      = hold_q + 1'b1;
`endif
                    if (owner_last) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            bus_data_q  <= bus_data_d;
            bus_valid_q <= bus_valid_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef BUS_SHARE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant     = grant_q;
    assign bus_data  = bus_data_q;
    assign bus_valid = bus_valid_q;
    assign owner     = owner_q;

endmodule
